// File: rtl/lut_pkg.sv
// Shared types and sizing helpers for the LUT configuration loader.
// The loader FSM walks IDLE -> LOAD -> RUN; DEPTH is always a power of two.
package lut_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } lut_cfg_state_e;

    function automatic int lut_depth(input int control_width);
        return 1 << control_width;
    endfunction

endpackage

// File: rtl/lut_cfg_mem.sv
// LUT storage: DEPTH x DATA_WIDTH register array, one synchronous write port
// and one combinational read port. Contents are deliberately never reset.
module lut_cfg_mem
    import lut_pkg::*;
#(
    parameter int DATA_WIDTH    = 4,
    parameter int CONTROL_WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [CONTROL_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [CONTROL_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    localparam int DEPTH = lut_depth(CONTROL_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lut_cfg_loader.sv
// Loads a DEPTH-entry LUT from a valid/ready config stream, then serves
// registered lookups (select + entry) to a downstream mux tree.
module lut_cfg_loader
    import lut_pkg::*;
#(
    parameter int DATA_WIDTH    = 4,
    parameter int CONTROL_WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cfg_start,
    input  logic                     cfg_valid,
    input  logic [DATA_WIDTH-1:0]    cfg_data,
    output logic                     cfg_ready,
    input  logic                     sel_valid,
    input  logic [CONTROL_WIDTH-1:0] sel_in,
    output logic [CONTROL_WIDTH-1:0] S,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     out_valid,
    output logic [CONTROL_WIDTH-1:0] load_addr,
    output logic                     loaded
);

    lut_cfg_state_e state, state_next;

    logic [CONTROL_WIDTH-1:0] addr_p0;
    logic                     loaded_p0;
    logic                     wr_en;
    logic                     last_word;
    logic                     lookup;
    logic [DATA_WIDTH-1:0]    rd_data;

    logic [CONTROL_WIDTH-1:0] sel_p1;
    logic [DATA_WIDTH-1:0]    data_p1;
    logic                     vld_p1;

    // cfg_start always wins: it discards a coincident config word or lookup.
    assign cfg_ready = (state == LOAD);
    assign wr_en     = cfg_ready && cfg_valid && !cfg_start;
    assign last_word = wr_en && (addr_p0 == '1);
    assign lookup    = (state == RUN) && sel_valid && !cfg_start;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cfg_start) state_next = LOAD;
            LOAD:    if (cfg_start) state_next = LOAD;
                     else if (last_word) state_next = RUN;
            RUN:     if (cfg_start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    // ---- stage p0: control state, write address, loaded flag ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr_p0   <= '0;
            loaded_p0 <= 1'b0;
        end else begin
            state <= state_next;
            if (cfg_start) begin
                addr_p0   <= '0;
                loaded_p0 <= 1'b0;
            end else if (wr_en) begin
                addr_p0 <= addr_p0 + CONTROL_WIDTH'(1);
                if (last_word) begin
                    loaded_p0 <= 1'b1;
                end
            end
        end
    end

    lut_cfg_mem #(
        .DATA_WIDTH    (DATA_WIDTH),
        .CONTROL_WIDTH (CONTROL_WIDTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (addr_p0),
        .wr_data (cfg_data),
        .rd_addr (sel_in),
        .rd_data (rd_data)
    );

    // ---- stage p1: registered lookup result, held while idle ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_p1  <= '0;
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= lookup;
            if (lookup) begin
                sel_p1  <= sel_in;
                data_p1 <= rd_data;
            end
        end
    end

    assign S         = sel_p1;
    assign data_out  = data_p1;
    assign out_valid = vld_p1;
    assign load_addr = addr_p0;
    assign loaded    = loaded_p0;

endmodule
